// File: rtl/alu_cmd_fifo.sv
// Command FIFO between debounced pushbuttons and an ALU accumulator: button edges
// write/issue {func, a} commands, and run drains one entry per clock.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_n,
  input  logic [CW-1:0]          cmd_in,
  input  logic                   go_n,
  input  logic                   run,
  output logic [3:0]             alu_a,
  output logic [2:0]             alu_func,
  output logic                   alu_en,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic          push_s1_q, push_s2_q, push_prev_q, push_arm_q;
  logic          go_s1_q, go_s2_q, go_prev_q, go_arm_q;
  logic [1:0]    settle_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q, count_d;
  logic [CW-1:0] mem_q [DEPTH];
  logic [CW-1:0] head;
  logic [3:0]    alu_a_q;
  logic [2:0]    alu_func_q;
  logic          alu_en_q, overflow_q, overflow_d;
  logic          push_edge, go_edge, pop_ok, push_ok;

  // An edge only counts once the synchronizer has shown a real high sample after
  // reset, so a button held low through reset release cannot fire a write.
  always_comb begin
    push_edge  = push_arm_q & ~push_s2_q & push_prev_q;
    go_edge    = go_arm_q & ~go_s2_q & go_prev_q;
    pop_ok     = (go_edge | run) & (count_q != '0);
    push_ok    = push_edge & ((count_q != CNTW'(DEPTH)) | pop_ok);
    head       = mem_q[rd_ptr_q];
    count_d    = count_q;
    if (push_ok && !pop_ok)
      count_d = count_q + CNTW'(1);
    else if (pop_ok && !push_ok)
      count_d = count_q - CNTW'(1);
    overflow_d = overflow_q | (push_edge & ~push_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_s1_q   <= 1'b1;
      push_s2_q   <= 1'b1;
      push_prev_q <= 1'b1;
      push_arm_q  <= 1'b0;
      go_s1_q     <= 1'b1;
      go_s2_q     <= 1'b1;
      go_prev_q   <= 1'b1;
      go_arm_q    <= 1'b0;
      settle_q    <= 2'd2;
    end else begin
      push_s1_q   <= push_n;
      push_s2_q   <= push_s1_q;
      push_prev_q <= push_s2_q;
      go_s1_q     <= go_n;
      go_s2_q     <= go_s1_q;
      go_prev_q   <= go_s2_q;
      if (settle_q != 2'd0)
        settle_q <= settle_q - 2'd1;
      // Settled synchronizer output now reflects the pin, not the reset value.
      if (settle_q == 2'd0 && push_s2_q)
        push_arm_q <= 1'b1;
      if (settle_q == 2'd0 && go_s2_q)
        go_arm_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      alu_a_q    <= '0;
      alu_func_q <= '0;
      alu_en_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
      alu_en_q   <= pop_ok;
      if (push_ok)
        wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok) begin
        rd_ptr_q   <= rd_ptr_q + AW'(1);
        alu_a_q    <= head[3:0];
        alu_func_q <= head[6:4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wr_ptr_q] <= cmd_in;
  end

  assign alu_a    = alu_a_q;
  assign alu_func = alu_func_q;
  assign alu_en   = alu_en_q;
  assign count    = count_q;
  assign full     = (count_q == CNTW'(DEPTH));
  assign empty    = (count_q == '0);
  assign overflow = overflow_q;
endmodule

// File: doc/alu_cmd_fifo.md
ALU_CMD_FIFO -- requirements
Module: alu_cmd_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of command entries; only powers of two ≥2 are legal.
REQ-002 SHALL have parameter CW, default 7, giving the command width as {func[2:0], a[3:0]}.
REQ-003 SHALL have port clk, input, 1, the single rising-edge clock for all state.
REQ-004 SHALL have port reset, input, 1, an asynchronous active-high reset.
REQ-005 SHALL have port push_n, input, 1, an active-low pushbutton level, asynchronous to clk, that requests a write.
REQ-006 SHALL have port cmd_in, input, CW, the command to write: bits [6:4] are func and bits [3:0] are the A operand.
REQ-007 SHALL have port go_n, input, 1, an active-low pushbutton level, asynchronous to clk, that requests a single issue.
REQ-008 SHALL have port run, input, 1, a level input that enables continuous issue.
REQ-009 SHALL have port alu_a, output, 4, the A operand of the last issued command.
REQ-010 SHALL have port alu_func, output, 3, the func of the last issued command.
REQ-011 SHALL have port alu_en, output, 1, a one-cycle load-enable pulse to the downstream ALU accumulator register.
REQ-012 SHALL have ports full, output, 1, and empty, output, 1, as FIFO status flags.
REQ-013 SHALL have port count, output, log2(DEPTH)+1, giving the number of stored entries.
REQ-014 SHALL have port overflow, output, 1, a sticky flag recording a dropped push.

Function
REQ-015 SHALL pass push_n and go_n each through a two-flop synchronizer followed by a previous-value flop; an edge is the synchronized value being 0 while the previous value is 1.
REQ-016 SHALL write cmd_in on the 3rd consecutive rising clk edge at which push_n is sampled low; cmd_in is sampled on that edge.
REQ-017 SHALL produce exactly one write per high-to-low transition of push_n, however long the button is held.
REQ-018 SHALL form a pop request on any clock edge where the synchronized go edge is present OR run=1.
REQ-019 SHALL treat a pop request with empty=1 as a no-op: no state change and alu_en=0.
REQ-020 SHALL handle a pop at edge P as follows: alu_a and alu_func take the head entry, the read pointer advances, and alu_en=1 for exactly the cycle following P.
REQ-021 SHALL hold alu_a and alu_func between pops.
REQ-022 SHALL, while run=1 and the FIFO is non-empty, issue one entry per clock; alu_en stays high across consecutive pops.
REQ-023 SHALL manage the FIFO as a circular buffer; both pointers wrap from DEPTH-1 to 0.
REQ-024 SHALL, on a push while full=1 with no pop on the same edge, drop the data, leave count unchanged and set overflow=1.
REQ-025 SHALL, on a push and pop on the same edge with the FIFO full, accept both, leave count unchanged and leave overflow unchanged.
REQ-026 SHALL, on a push and pop on the same edge with the FIFO empty, ignore the pop, accept the push and set count=1; no bypass to alu_a.
REQ-027 SHALL, on a push and pop on the same edge otherwise, accept both and leave count unchanged.
REQ-028 SHALL drive full=(count==DEPTH) and empty=(count==0), both registered-consistent with count.
REQ-029 SHALL clear overflow only by reset.

Reset
REQ-030 SHALL, while reset=1, asynchronously force: alu_a=0, alu_func=0, alu_en=0, count=0, empty=1, full=0, overflow=0, both pointers=0.
REQ-031 SHALL, while reset=1, force all synchronizer and previous-value flops to 1, so a button held low through reset release produces no edge.
REQ-032 SHALL not preserve any stored entries across reset.
REQ-033 SHALL treat a push or pop in progress in the synchronizer at reset assertion as lost.

Verification
REQ-034 SHALL pass single push/issue: cmd_in=7'b001_0011, pulse push_n low 5 cycles, then pulse go_n -> count 0→1→0; alu_func=3'b001, alu_a=4'h3; alu_en high exactly 1 cycle.
REQ-035 SHALL pass fill/overflow: 5 push pulses with cmd_in a=1..5 -> after the 4th, full=1 and count=4; the 5th is dropped and overflow=1; run=1 then issues a=1,2,3,4 on consecutive cycles with alu_en high 4 cycles, and empty=1 afterwards.
REQ-036 SHALL pass the full-boundary push+pop: with the FIFO full, align the push edge with a go pop -> count stays 4, overflow stays 0, and the new entry emerges 4th.
REQ-037 SHALL pass pop on empty: go_n pulse with count=0 -> alu_en stays 0, and alu_a/alu_func keep their prior values.
REQ-038 SHALL pass long hold: push_n held low 50 cycles -> exactly one write occurs.
REQ-039 SHALL pass reset mid-operation: assert reset with count=3 while run=0 and push_n held low -> all outputs take their REQ-030 values immediately, and no write occurs after release until push_n toggles.
